regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32×32 `register_file`. It shares the register file's single write port (`r_wr_en`/`w_reg`/`w_data`) between the ALU writeback path and the load (memory) writeback path. Each source has a small buffer, and the block grants one write per cycle round-robin. It also exposes a pending-write hazard query to the issue stage. It sits between the execute/memory stages and `register_file`.

---
 rtl/mips_pkg.sv | 17 +
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared writeback types and widths for the register-file write-port arbiter.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } grant_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-source writeback FIFO with per-entry valid/destination taps
// so the top can answer pending-write hazard queries.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  wb_req_t                       i_pushReq,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output wb_req_t                       o_head,
    output logic [DEPTH-1:0]              o_entryValid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_entryReg
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;

    logic             w_doPush;
    logic             w_doPop;
    logic [DEPTH-1:0] w_validNext;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];

    // Pop clears before push sets; a push never targets the head slot while it is occupied.
    always_comb begin
        w_validNext = r_valid;
        if (w_doPop) begin
            w_validNext[r_rdPtr] = 1'b0;
        end
        if (w_doPush) begin
            w_validNext[r_wrPtr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= w_validNext;
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CW'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushReq;
        end
    end

    always_comb begin
        o_entryValid = r_valid;
        for (int i = 0; i < DEPTH; i++) begin
            o_entryReg[i] = r_mem[i].dst;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback,
// round-robin per cycle, with a pending-write hazard query for issue.
module regfile_wb_arbiter #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              r_wr_en,
    output logic [ADDR_W-1:0] w_reg,
    output logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] q_reg,
    output logic              q_hit
);

    mips_pkg::grant_state_t r_state;
    mips_pkg::grant_state_t w_stateNext;

    mips_pkg::wb_req_t w_aluReq, w_memReq, w_aluHead, w_memHead;
    logic w_aluPush, w_memPush, w_aluFull, w_memFull, w_aluEmpty, w_memEmpty;
    logic w_grantAlu, w_grantMem;
    logic [DEPTH-1:0]                       w_aluValidTap, w_memValidTap;
    logic [DEPTH-1:0][mips_pkg::ADDR_W-1:0] w_aluRegTap, w_memRegTap;

    assign alu_ready = !rst && !w_aluFull;
    assign mem_ready = !rst && !w_memFull;

    // Writes to r0 complete the handshake but are dropped here.
    assign w_aluPush = alu_valid && alu_ready && (alu_reg != '0);
    assign w_memPush = mem_valid && mem_ready && (mem_reg != '0);
    assign w_aluReq  = '{dst: alu_reg, data: alu_data};
    assign w_memReq  = '{dst: mem_reg, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_aluFifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_aluPush),
        .i_pushReq    (w_aluReq),
        .i_pop        (w_grantAlu),
        .o_full       (w_aluFull),
        .o_empty      (w_aluEmpty),
        .o_head       (w_aluHead),
        .o_entryValid (w_aluValidTap),
        .o_entryReg   (w_aluRegTap)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_memFifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_memPush),
        .i_pushReq    (w_memReq),
        .i_pop        (w_grantMem),
        .o_full       (w_memFull),
        .o_empty      (w_memEmpty),
        .o_head       (w_memHead),
        .o_entryValid (w_memValidTap),
        .o_entryReg   (w_memRegTap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= mips_pkg::LAST_MEM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // On contention the source not granted last wins; otherwise any non-empty source.
    always_comb begin
        w_grantAlu  = 1'b0;
        w_grantMem  = 1'b0;
        w_stateNext = r_state;
        if (!w_aluEmpty && (w_memEmpty || r_state == mips_pkg::LAST_MEM)) begin
            w_grantAlu  = 1'b1;
            w_stateNext = mips_pkg::LAST_ALU;
        end else if (!w_memEmpty) begin
            w_grantMem  = 1'b1;
            w_stateNext = mips_pkg::LAST_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            w_reg   <= '0;
            w_data  <= '0;
        end else if (w_grantAlu) begin
            r_wr_en <= 1'b1;
            w_reg   <= w_aluHead.dst;
            w_data  <= w_aluHead.data;
        end else if (w_grantMem) begin
            r_wr_en <= 1'b1;
            w_reg   <= w_memHead.dst;
            w_data  <= w_memHead.data;
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    always_comb begin
        q_hit = r_wr_en && (w_reg == q_reg);
        for (int i = 0; i < DEPTH; i++) begin
            if ((w_aluValidTap[i] && w_aluRegTap[i] == q_reg) ||
                (w_memValidTap[i] && w_memRegTap[i] == q_reg)) begin
                q_hit = 1'b1;
            end
        end
        if (q_reg == '0) begin
            q_hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: latency, arbitration order,
// backpressure, r0 suppression, hazard query and mid-operation reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_reg, mem_reg, w_reg, q_reg;
    logic [31:0] alu_data, mem_data, w_data;
    logic        r_wr_en, q_hit;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] rf [32];
    logic [36:0] writeLog [$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .r_wr_en   (r_wr_en),
        .w_reg     (w_reg),
        .w_data    (w_data),
        .q_reg     (q_reg),
        .q_hit     (q_hit)
    );

    // Behavioural register file sink and write trace.
    always @(posedge clk) begin
        if (r_wr_en) rf[w_reg] <= w_data;
    end

    always @(negedge clk) begin
        if (r_wr_en) writeLog.push_back({w_reg, w_data});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        writeLog.delete();
    endtask

    int          aRegs [4] = '{4, 5, 6, 8};
    int          mRegs [4] = '{9, 10, 11, 12};
    logic [36:0] expEntry;

    initial begin
        int  ai, mi;
        logic aAcc, mAcc, sawFull;

        rst   = 1'b1;
        q_reg = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        checkOutput("rstAluReady", alu_ready, 0);
        checkOutput("rstMemReady", mem_ready, 0);
        checkOutput("rstWrEn", r_wr_en, 0);
        checkOutput("rstWReg", w_reg, 0);
        checkOutput("rstWData", w_data, 0);
        rst = 1'b0;
        #1;
        checkOutput("postRstReady", {alu_ready, mem_ready}, 2'b11);

        // Single ALU write: r3 <= 100
        doReset();
        applyStimulus(1, 5'd3, 32'd100, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        q_reg = 5'd3;
        #1;
        checkOutput("singleWrEnEarly", r_wr_en, 0);
        checkOutput("singleHitQueued", q_hit, 1);
        step();
        checkOutput("singleWrEn", r_wr_en, 1);
        checkOutput("singleWReg", w_reg, 3);
        checkOutput("singleWData", w_data, 100);
        checkOutput("singleHitOut", q_hit, 1);
        step();
        checkOutput("singleRf3", rf[3], 100);
        checkOutput("singleWrEnDone", r_wr_en, 0);
        checkOutput("singleHitDone", q_hit, 0);
        q_reg = '0;

        // Simultaneous first requests: ALU wins the first tie
        doReset();
        applyStimulus(1, 5'd1, 32'd11, 1, 5'd2, 32'd22);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        checkOutput("tieFirst", {r_wr_en, w_reg, w_data}, {1'b1, 5'd1, 32'd11});
        step();
        checkOutput("tieSecond", {r_wr_en, w_reg, w_data}, {1'b1, 5'd2, 32'd22});
        step();
        checkOutput("tieIdle", {r_wr_en, w_reg, w_data}, {1'b0, 5'd2, 32'd22});

        // Backpressure: 4 ALU and 4 MEM requests contending every cycle
        doReset();
        ai = 0; mi = 0; sawFull = 0;
        for (int cyc = 0; cyc < 40 && (ai < 4 || mi < 4); cyc++) begin
            applyStimulus(ai < 4, 5'(aRegs[ai % 4]), 32'hA0 + 32'(ai),
                          mi < 4, 5'(mRegs[mi % 4]), 32'hB0 + 32'(mi));
            @(negedge clk);
            aAcc = alu_valid && alu_ready;
            mAcc = mem_valid && mem_ready;
            if (alu_valid && !alu_ready) sawFull = 1;
            step();
            if (aAcc) ai++;
            if (mAcc) mi++;
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bpDone", {ai[3:0], mi[3:0]}, 8'h44);
        checkOutput("bpSawFull", sawFull, 1);
        repeat (6) step();
        checkOutput("bpCount", writeLog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) expEntry = {5'(aRegs[k / 2]), 32'hA0 + 32'(k / 2)};
            else            expEntry = {5'(mRegs[k / 2]), 32'hB0 + 32'(k / 2)};
            checkOutput($sformatf("bpWrite%0d", k), (k < writeLog.size()) ? writeLog[k] : 37'h0, expEntry);
        end

        // r0 write is accepted but never issued
        doReset();
        applyStimulus(0, 0, 0, 1, 5'd0, 32'd55);
        #1;
        checkOutput("r0Ready", mem_ready, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        q_reg = '0;
        #1;
        checkOutput("r0NoHit", q_hit, 0);
        step();
        step();
        checkOutput("r0NoWrites", writeLog.size(), 0);

        // Hazard query for a pending r7 write
        applyStimulus(1, 5'd7, 32'd77, 0, 0, 0);
        q_reg = 5'd7;
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hitPending", q_hit, 1);
        q_reg = 5'd0;
        #1;
        checkOutput("hitZeroReg", q_hit, 0);
        q_reg = 5'd6;
        #1;
        checkOutput("hitOtherReg", q_hit, 0);
        q_reg = 5'd7;
        step();
        checkOutput("hitWrCycle", {r_wr_en, q_hit}, 2'b11);
        step();
        checkOutput("hitCleared", q_hit, 0);
        q_reg = '0;

        // Reset with writes queued and one in flight
        doReset();
        applyStimulus(1, 5'd10, 32'hC1, 1, 5'd11, 32'hD1);
        step();
        step();
        step();
        checkOutput("midBusy", r_wr_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("midReadyLow", {alu_ready, mem_ready}, 2'b00);
        step();
        checkOutput("midWrCancel", {r_wr_en, w_reg}, 6'd0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        writeLog.delete();
        repeat (5) step();
        checkOutput("midNoStale", writeLog.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
